// File: rtl/fifo_sync_ext_if.sv
// fifo_sync_ext_if: handshake/status bundle for fifo_sync_ext.
//   slave  : FIFO side (takes requests and data, drives q, count and flags)
//   master : client side (drives requests and data, observes q and flags)
// Parameters: ADDR_WIDTH (log2 depth), DATA_WIDTH (word width).
interface fifo_sync_ext_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  flush;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] data;
  logic                  rd_req;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic [ADDR_WIDTH:0]   fifo_num;
  logic                  rd_empty;
  logic                  wr_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  flush, wr_req, data, rd_req, clr_err,
    output q, q_valid, fifo_num, rd_empty, wr_full,
           almost_full, almost_empty, overflow, underflow
  );

  modport master (
    output flush, wr_req, data, rd_req, clr_err,
    input  q, q_valid, fifo_num, rd_empty, wr_full,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_ext.sv
// fifo_sync_ext: single-clock FIFO with standard or first-word-fall-through
// read mode, almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - fifo_sync_ext_if.slave (requests, data, q, count, flags)
module fifo_sync_ext #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_sync_ext_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_N = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_N    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_N    = (ADDR_WIDTH+1)'(AE_LEVEL);

  if (ADDR_WIDTH < 1 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
    $fatal(1, "fifo_sync_ext: illegal ADDR_WIDTH/AE_LEVEL/AF_LEVEL combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  empty;
  logic                  full;
  logic                  wa;
  logic                  ra;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_N);

  // Accept decisions use only registered state; flush swallows both requests.
  assign wa = bus.wr_req & ~full  & ~bus.flush;
  assign ra = bus.rd_req & ~empty & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wa) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (ra) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        count <= count + {{ADDR_WIDTH{1'b0}}, wa} - {{ADDR_WIDTH{1'b0}}, ra};
      end
      // A fresh error in the same cycle as clr_err keeps the flag set.
      if (bus.wr_req & full & ~bus.flush)      overflow_r <= 1'b1;
      else if (bus.clr_err)                    overflow_r <= 1'b0;
      if (bus.rd_req & empty & ~bus.flush)     underflow_r <= 1'b1;
      else if (bus.clr_err)                    underflow_r <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr] <= bus.data;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.q       = empty ? '0 : mem[rd_ptr];
    assign bus.q_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] q_r;
    logic                  q_valid_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        q_r       <= '0;
        q_valid_r <= 1'b0;
      end else if (ra) begin
        q_r       <= mem[rd_ptr];
        q_valid_r <= 1'b1;
      end else begin
        q_valid_r <= 1'b0;
      end
    end

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
  end

  assign bus.fifo_num     = count;
  assign bus.rd_empty     = empty;
  assign bus.wr_full      = full;
  assign bus.almost_full  = (count >= AF_N);
  assign bus.almost_empty = (count <= AE_N);
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync_ext.sv
// tb_fifo_sync_ext: drives a standard-mode and an FWFT-mode fifo_sync_ext
// with identical stimulus and compares both against a queue-based model.
module tb_fifo_sync_ext;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, wr_req, rd_req, clr_err;
  logic [DW-1:0] data;

  fifo_sync_ext_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bs ();
  fifo_sync_ext_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bf ();

  assign bs.flush = flush;   assign bf.flush = flush;
  assign bs.wr_req = wr_req; assign bf.wr_req = wr_req;
  assign bs.data = data;     assign bf.data = data;
  assign bs.rd_req = rd_req; assign bf.rd_req = rd_req;
  assign bs.clr_err = clr_err; assign bf.clr_err = clr_err;

  fifo_sync_ext #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
    dut_std (.clk(clk), .rst(rst), .bus(bs.slave));
  fifo_sync_ext #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
    dut_fw (.clk(clk), .rst(rst), .bus(bf.slave));

  // Reference model: stored words as a queue plus sticky flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] std_exp[$];
  logic [DW-1:0] m_lastq;
  bit            m_ovf, m_unf;
  bit            mon_en = 1'b0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs after each edge against the model.
  always @(negedge clk) begin
    int n;
    if (mon_en) begin
      n = mq.size();
      chk("num_std", 32'(bs.fifo_num), n);
      chk("num_fw", 32'(bf.fifo_num), n);
      chk("empty", 32'(bs.rd_empty), 32'(n == 0));
      chk("full", 32'(bs.wr_full), 32'(n == D));
      chk("almost_full", 32'(bs.almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(bs.almost_empty), 32'(n <= AE));
      chk("fw_flags", {bf.rd_empty, bf.wr_full, bf.almost_full, bf.almost_empty},
          {n == 0, n == D, n >= AF, n <= AE});
      chk("overflow", {bs.overflow, bf.overflow}, {m_ovf, m_ovf});
      chk("underflow", {bs.underflow, bf.underflow}, {m_unf, m_unf});
      if (bs.q_valid) begin
        if (std_exp.size() == 0) chk("std_qv_spurious", 32'(bs.q_valid), 0);
        else chk("std_q", 32'(bs.q), 32'(std_exp.pop_front()));
      end else begin
        chk("std_qv_missing", std_exp.size(), 0);
        std_exp.delete();
        chk("std_q_hold", 32'(bs.q), 32'(m_lastq));
      end
      chk("fw_qv", 32'(bf.q_valid), 32'(n != 0));
      chk("fw_q", 32'(bf.q), (n != 0) ? 32'(mq[0]) : 0);
    end
  end

  // Apply one cycle of inputs, then advance the model across the edge.
  task automatic step(bit w, logic [DW-1:0] d, bit r, bit f, bit c, bit rs);
    int n;
    logic [DW-1:0] pv;
    wr_req = w; data = d; rd_req = r; flush = f; clr_err = c; rst = rs;
    @(posedge clk);
    n = mq.size();
    if (rs) begin
      mq.delete(); std_exp.delete();
      m_ovf = 0; m_unf = 0; m_lastq = '0;
    end else if (f) begin
      mq.delete();
      if (c) begin m_ovf = 0; m_unf = 0; end
    end else begin
      if (w && n == D) m_ovf = 1; else if (c) m_ovf = 0;
      if (r && n == 0) m_unf = 1; else if (c) m_unf = 0;
      if (r && n > 0) begin
        pv = mq.pop_front();
        std_exp.push_back(pv);
        m_lastq = pv;
      end
      if (w && n < D) mq.push_back(d);
    end
    #1;
    mon_en = 1'b1;
  endtask

  task automatic wr(logic [DW-1:0] d); step(1, d, 0, 0, 0, 0); endtask
  task automatic rd();                 step(0, 0, 1, 0, 0, 0); endtask
  task automatic idle();               step(0, 0, 0, 0, 0, 0); endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle();
    // fill, overflow, drain, underflow, clear
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55);
    rd(); rd(); rd(); rd(); rd(); idle();
    step(0, 0, 0, 0, 1, 0);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    step(1, 8'h66, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    rd(); rd(); rd(); rd(); idle();
    // simultaneous read/write at two words, then at full
    wr(8'hA0); wr(8'hA1);
    for (int i = 0; i < 3; i++) step(1, 8'hB0 + 8'(i), 1, 0, 0, 0);
    wr(8'hC0); wr(8'hC1);
    step(1, 8'hC2, 1, 0, 0, 0);
    rd(); rd(); rd(); idle();
    step(0, 0, 0, 0, 1, 0);
    // pointer wrap
    for (int i = 0; i < 10; i++) begin wr(8'(i)); rd(); end
    idle();
    // FWFT single word
    wr(8'hA5); idle(); rd(); idle();
    // flush with a concurrent write at three words
    wr(8'h71); wr(8'h72); wr(8'h73);
    step(1, 8'h74, 0, 1, 0, 0);
    idle();
    // reset mid-drain
    wr(8'h81); wr(8'h82); wr(8'h83); wr(8'h84);
    rd(); rd();
    step(0, 0, 1, 0, 0, 1);
    idle();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 149) == 0);
    end
    idle(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
